// File: rtl/rail_rush_obstacles.sv
// ---------------------------------------------------------------------------
// rail_rush_obstacles
//
// Obstacle manager for the Rail Rush endless-runner game. Keeps four
// obstacle slots that scroll down the screen, spawns new obstacles from a
// 16-bit Galois LFSR on a pseudo-random frame timer, and checks the player
// against every slot once per frame.
//
// Optional feature macro: RAIL_RUSH_COIN_EN
//   defined   -> LFSR kind 1x spawns a coin; coins are collected in the band
//   undefined -> kind 1x spawns a barrier, coin_collected is tied low
//
// Ports
//   clock          system clock
//   reset_n        asynchronous active-low reset
//   frame_done     one-cycle end-of-frame pulse, the only update strobe
//   game_active    gameplay running
//   speed          scroll speed, pixels per frame
//   player_lane    player lane, 0..2
//   player_jump    player is airborne (clears barriers)
//   obstacle_hit   registered collision result of the last frame
//   coin_collected registered coin pickup of the last frame
//   slot_valid     per-slot occupancy
//   slot_lane      2 bits per slot
//   slot_kind      2 bits per slot: 00 barrier, 01 train, 10 coin
//   slot_y         10 bits per slot, top edge y
// ---------------------------------------------------------------------------
module rail_rush_obstacles #(
    parameter int          SCREEN_H  = 480,
    parameter int          HIT_Y_MIN = 400,
    parameter int          HIT_Y_MAX = 447,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        frame_done,
    input  logic        game_active,
    input  logic [3:0]  speed,
    input  logic [1:0]  player_lane,
    input  logic        player_jump,
    output logic        obstacle_hit,
    output logic        coin_collected,
    output logic [3:0]  slot_valid,
    output logic [7:0]  slot_lane,
    output logic [7:0]  slot_kind,
    output logic [39:0] slot_y
);

    typedef enum logic {
        STATE_CLEAR,
        STATE_RUN
    } state_t;

    localparam logic [1:0]  KIND_BARRIER = 2'b00;
    localparam logic [1:0]  KIND_TRAIN   = 2'b01;
`ifdef RAIL_RUSH_COIN_EN
    localparam logic [1:0]  KIND_COIN    = 2'b10;
`endif
    localparam logic [10:0] SCREEN_LIMIT = 11'(SCREEN_H);
    localparam logic [9:0]  BAND_TOP     = 10'(HIT_Y_MIN);
    localparam logic [9:0]  BAND_BOTTOM  = 10'(HIT_Y_MAX);
    localparam logic [5:0]  TIMER_RESET  = 6'd20;
    localparam logic [15:0] LFSR_MASK    = 16'hB400;

    state_t      state;
    state_t      next_state;
    logic        clear_all;
    logic        frame_step;

    logic [15:0] lfsr;
    logic [15:0] lfsr_next;
    logic [5:0]  timer;
    logic [5:0]  timer_next;
    logic        hit_next;
    logic [3:0]  valid_next;
    logic [7:0]  lane_next;
    logic [7:0]  kind_next;
    logic [39:0] y_next;

    logic [10:0] moved_y [4];
    logic [3:0]  in_band;
    logic [3:0]  hits_slot;
    logic [3:0]  coin_take;

    logic        spawn_ok;
    logic [1:0]  spawn_idx;
    logic [1:0]  spawn_lane;
    logic [1:0]  spawn_kind;

    // Controller state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= STATE_CLEAR;
        end else begin
            state <= next_state;
        end
    end

    // The game starts as soon as game_active is seen and stops on the very
    // first cycle it drops.
    always_comb begin
        next_state = state;
        case (state)
            STATE_CLEAR: next_state = game_active ? STATE_RUN : STATE_CLEAR;
            STATE_RUN:   next_state = game_active ? STATE_RUN : STATE_CLEAR;
            default:     next_state = STATE_CLEAR;
        endcase
    end

    // Controller outputs. Clearing is keyed on the drop of game_active itself
    // so the slots are already empty on the cycle after the game stops.
    always_comb begin
        clear_all  = (state == STATE_CLEAR) || !game_active;
        frame_step = (state == STATE_RUN) && game_active && frame_done;
    end

    // Per-slot scroll sum and collision test, all on the current slot
    // contents. The sum is 11 bits so a slot near the bottom cannot wrap.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            moved_y[i]   = {1'b0, slot_y[10*i +: 10]} + {7'b0, speed};
            in_band[i]   = slot_valid[i]
                           && (slot_lane[2*i +: 2] == player_lane)
                           && (slot_y[10*i +: 10] >= BAND_TOP)
                           && (slot_y[10*i +: 10] <= BAND_BOTTOM);
            hits_slot[i] = in_band[i]
                           && ((slot_kind[2*i +: 2] == KIND_TRAIN)
                               || ((slot_kind[2*i +: 2] == KIND_BARRIER) && !player_jump));
`ifdef RAIL_RUSH_COIN_EN
            coin_take[i] = in_band[i] && (slot_kind[2*i +: 2] == KIND_COIN);
`else
            coin_take[i] = 1'b0;
`endif
        end
    end

    // Spawn target is the lowest-index slot that is free before this frame's
    // update, so a slot freed on the same edge is never reused right away.
    always_comb begin
        spawn_ok  = 1'b0;
        spawn_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!slot_valid[i]) begin
                spawn_ok  = 1'b1;
                spawn_idx = 2'(i);
            end
        end
        spawn_lane = (lfsr[1:0] == 2'd3) ? 2'd1 : lfsr[1:0];
`ifdef RAIL_RUSH_COIN_EN
        spawn_kind = lfsr[3] ? KIND_COIN : {1'b0, lfsr[2]};
`else
        spawn_kind = lfsr[3] ? KIND_BARRIER : {1'b0, lfsr[2]};
`endif
    end

    // Frame update of slots, spawn timer and LFSR. Freed slots have their
    // fields zeroed so the renderer bus is deterministic.
    always_comb begin
        valid_next = slot_valid;
        lane_next  = slot_lane;
        kind_next  = slot_kind;
        y_next     = slot_y;
        lfsr_next  = lfsr;
        timer_next = timer;
        hit_next   = obstacle_hit;
        if (clear_all) begin
            valid_next = '0;
            lane_next  = '0;
            kind_next  = '0;
            y_next     = '0;
            lfsr_next  = LFSR_SEED;
            timer_next = TIMER_RESET;
            hit_next   = 1'b0;
        end else if (frame_step) begin
            hit_next = |hits_slot;
            for (int i = 0; i < 4; i++) begin
                if (slot_valid[i]) begin
                    if (coin_take[i] || (moved_y[i] >= SCREEN_LIMIT)) begin
                        valid_next[i]        = 1'b0;
                        lane_next[2*i +: 2]  = '0;
                        kind_next[2*i +: 2]  = '0;
                        y_next[10*i +: 10]   = '0;
                    end else begin
                        y_next[10*i +: 10]   = moved_y[i][9:0];
                    end
                end
            end
            if (timer == 6'd0) begin
                if (spawn_ok) begin
                    valid_next[spawn_idx]         = 1'b1;
                    lane_next[2*spawn_idx +: 2]   = spawn_lane;
                    kind_next[2*spawn_idx +: 2]   = spawn_kind;
                    y_next[10*spawn_idx +: 10]    = '0;
                end
                timer_next = TIMER_RESET + {1'b0, lfsr[8:4]};
            end else begin
                timer_next = timer - 6'd1;
            end
            lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_MASK : 16'h0000);
        end
    end

    // Datapath registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            slot_valid   <= '0;
            slot_lane    <= '0;
            slot_kind    <= '0;
            slot_y       <= '0;
            lfsr         <= LFSR_SEED;
            timer        <= TIMER_RESET;
            obstacle_hit <= 1'b0;
        end else begin
            slot_valid   <= valid_next;
            slot_lane    <= lane_next;
            slot_kind    <= kind_next;
            slot_y       <= y_next;
            lfsr         <= lfsr_next;
            timer        <= timer_next;
            obstacle_hit <= hit_next;
        end
    end

`ifdef RAIL_RUSH_COIN_EN
    logic coin_next;

    // Coin pickup flag: one frame long, several coins still give one pulse.
    always_comb begin
        coin_next = coin_collected;
        if (clear_all) begin
            coin_next = 1'b0;
        end else if (frame_step) begin
            coin_next = |coin_take;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            coin_collected <= 1'b0;
        end else begin
            coin_collected <= coin_next;
        end
    end
`else
    assign coin_collected = 1'b0;
`endif

endmodule
